load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, plus rs2 as store data. It performs byte, halfword and word accesses to data memory over a request/acknowledge handshake, and returns sign- or zero-extended load data to writeback. It checks alignment and funct3 legality before any memory access is issued.

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: checks funct3 and alignment, then runs one request/acknowledge memory access.
// Latency: 2 + wait cycles from accept to response (1 on error). Backpressure: req_ready is high only in IDLE.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        legal, misal;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE);

  // Decode of the incoming request; only sampled on the accept edge.
  always_comb begin
    legal     = 1'b0;
    be_dec    = 4'b1111;
    wdata_dec = store_data;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !op_store;
      default:                legal = 1'b0;
    endcase
    misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
            ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << addr[1:0];
        wdata_dec = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_dec    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{store_data[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = store_data;
      end
    endcase
  end

  always_comb begin
    byte_lane = mem_rdata[{lo_q, 3'b000} +: 8];
    half_lane = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'b0, byte_lane};
      3'b101:  load_ext = {16'b0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = (legal && !misal) ? ACCESS : RESP;
        end
      end
      ACCESS:  if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'b0;
      mem_be     <= 4'b0;
      mem_wdata  <= 32'b0;
      resp_valid <= 1'b0;
      resp_err   <= 2'b00;
      load_data  <= 32'b0;
      f3_q       <= 3'b0;
      lo_q       <= 2'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 2'b00;
      load_data  <= 32'b0;
      if (accept) begin
        if (!legal) begin
          resp_valid <= 1'b1;
          resp_err   <= 2'b10;
        end else if (misal) begin
          resp_valid <= 1'b1;
          resp_err   <= 2'b01;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= op_store;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_be    <= be_dec;
          mem_wdata <= wdata_dec;
          f3_q      <= funct3;
          lo_q      <= addr[1:0];
        end
      end
      // An ack only completes an access while one is actually outstanding.
      if (state == ACCESS && mem_ack) begin
        mem_req    <= 1'b0;
        resp_valid <= 1'b1;
        load_data  <= mem_we ? 32'b0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver queues expected memory accesses and responses,
// separate monitors compare them against the memory port and the response port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        op_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] store_data = 32'b0;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op_store(op_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] data;
    int          at;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    int          hold;
  } mem_t;

  resp_t rq[$];
  mem_t  mq[$];
  resp_t re;
  mem_t  me;
  bit    me_ok = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ack_delay = 0;
  int    mcnt = 0;
  int    last_accept = 0;
  int    acc1, acc2, acc3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid with err %b data %h, expected none (cycle %0d)",
                 resp_err, load_data, cyc);
      end else begin
        re = rq.pop_front();
        chk("resp_err", 32'(resp_err), 32'(re.err));
        chk("load_data", load_data, re.data);
        chk("resp_cycle", 32'(cyc), 32'(re.at));
      end
    end
  end

  // Memory model and monitor: acks after ack_delay wait cycles, checks controls stay constant.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end else if (mem_req) begin
      if (mcnt == 0) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          me_ok = 1'b0;
          $display("FAIL unexpected_mem_req: got mem_req addr %h, expected none (cycle %0d)", mem_addr, cyc);
        end else begin
          me    = mq.pop_front();
          me_ok = 1'b1;
        end
      end
      if (me_ok) begin
        chk("mem_we", 32'(mem_we), 32'(me.we));
        chk("mem_addr", mem_addr, me.a);
        chk("mem_be", 32'(mem_be), 32'(me.be));
        chk("mem_wdata", mem_wdata, me.wd);
      end
      mem_ack = (mcnt == ack_delay);
      mcnt++;
    end else begin
      if (mcnt != 0 && me_ok) chk("mem_req_hold", 32'(mcnt), 32'(me.hold));
      mcnt    = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [1:0] err, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] wd, input int dly,
                       input bit expect_resp);
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    op_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    ack_delay  = dly;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 for %0d cycles, expected 1", n);
      req_valid = 1'b0;
      return;
    end
    last_accept = cyc;
    if (err == 2'b00) mq.push_back('{st, {a[31:2], 2'b00}, be, wd, dly + 1});
    if (expect_resp) rq.push_back('{err, data, cyc + ((err != 2'b00) ? 1 : 2 + dly)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Legal loads and stores
    mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 1'b1); idle(3);
    mem_rdata = 32'h80FF1234;
    issue(1'b0, 3'b000, 32'h103, 32'h0, 2'b00, 32'hFFFFFF80, 4'b1000, 32'h0, 0, 1'b1); idle(3);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 2'b00, 32'h00000080, 4'b1000, 32'h0, 0, 1'b1); idle(3);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 2'b00, 32'hFFFF80FF, 4'b1100, 32'h0, 1, 1'b1); idle(3);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 2'b00, 32'h000080FF, 4'b1100, 32'h0, 0, 1'b1); idle(3);
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 2'b00, 32'h0, 4'b1100, 32'hABCDABCD, 3, 1'b1); idle(6);
    issue(1'b1, 3'b000, 32'h301, 32'h000000A5, 2'b00, 32'h0, 4'b0010, 32'hA5A5A5A5, 0, 1'b1); idle(3);
    issue(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 2'b00, 32'h0, 4'b1111, 32'hCAFEF00D, 2, 1'b1); idle(5);

    // Error responses: no memory access, response one cycle after accept
    issue(1'b0, 3'b010, 32'h102, 32'h0, 2'b01, 32'h0, 4'b0, 32'h0, 0, 1'b1); idle(3);
    issue(1'b0, 3'b001, 32'h101, 32'h0, 2'b01, 32'h0, 4'b0, 32'h0, 0, 1'b1); idle(3);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 2'b10, 32'h0, 4'b0, 32'h0, 0, 1'b1); idle(3);
    issue(1'b1, 3'b100, 32'h101, 32'h55, 2'b10, 32'h0, 4'b0, 32'h0, 0, 1'b1); idle(3);
    issue(1'b1, 3'b001, 32'h203, 32'h77, 2'b01, 32'h0, 4'b0, 32'h0, 0, 1'b1); idle(3);

    // Back-to-back stream with req_valid held high
    mem_rdata = 32'h11223344;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 2'b00, 32'h11223344, 4'b1111, 32'h0, 0, 1'b1);
    acc1 = last_accept;
    issue(1'b0, 3'b100, 32'h11, 32'h0, 2'b00, 32'h00000033, 4'b0010, 32'h0, 0, 1'b1);
    acc2 = last_accept;
    issue(1'b0, 3'b001, 32'h12, 32'h0, 2'b00, 32'h00001122, 4'b1100, 32'h0, 0, 1'b1);
    acc3 = last_accept;
    idle(4);
    chk("stream_spacing_1", 32'(acc2 - acc1), 32'd3);
    chk("stream_spacing_2", 32'(acc3 - acc2), 32'd3);

    // Reset during an access that never gets acknowledged
    issue(1'b0, 3'b010, 32'h500, 32'h0, 2'b00, 32'h0, 4'b1111, 32'h0, 50, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("mem_req_before_rst", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mem_req_async_drop", 32'(mem_req), 32'd0);
    chk("req_ready_in_rst", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    idle(2);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);
    mem_rdata = 32'h0BADF00D;
    issue(1'b0, 3'b010, 32'h600, 32'h0, 2'b00, 32'h0BADF00D, 4'b1111, 32'h0, 0, 1'b1);
    idle(10);

    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
